counter_ctrl: RTL and testbench

- Run/pause/clear controller for the two-digit BCD counter datapath.
- Debounces the front-panel buttons and replaces the free-running 1 Hz divider with a gated tick generator.
- Emits single-cycle count-enable and clear strobes, a direction level and a display-hold flag.
- Watches the counter's BCD outputs to stop at the terminal value.

---
 rtl/ctrl_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/counter_ctrl.sv | 138 +++++++++++++
 tb/tb_counter_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the BCD counter run/pause/clear controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } ctrl_state_e;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam logic [3:0] BCD_MIN_DIGIT = 4'd0;

    // Terminal value depends on direction: 99 counting up, 00 counting down.
    function automatic logic is_terminal(input logic [3:0] tens,
                                         input logic [3:0] ones,
                                         input logic       up);
        if (up)
            return (tens == BCD_MAX_DIGIT) && (ones == BCD_MAX_DIGIT);
        else
            return (tens == BCD_MIN_DIGIT) && (ones == BCD_MIN_DIGIT);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability down-counter and rising-edge press pulse
// for one front-panel button.
module btn_debounce
    import ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int            CW     = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] stab_q, stab_d;

    // Counter reloads whenever the synchronized input agrees with the
    // accepted level, so any bounce back restarts the stability window.
    always_comb begin
        level_d = level_q;
        stab_d  = RELOAD;
        if (sync2_q != level_q) begin
            if (stab_q == '0)
                level_d = sync2_q;
            else
                stab_d = stab_q - 1'b1;
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            stab_q  <= RELOAD;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            stab_q  <= stab_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/clear controller for the two-digit BCD counter: debounced
// buttons, gated tick divider, terminal-count stop.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | cleared, waiting for start
// ST_RUN   | divider running, cnt_en issued on each tick
// ST_PAUSE | divider frozen at its current value
// ST_DONE  | terminal count reached, only clear leaves
module counter_ctrl
    import ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int STOP_AT_END = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    input  logic       toggle,
    input  logic [3:0] bcd_1,
    input  logic [3:0] bcd_10,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       cnt_up,
    output logic       disp_hold,
    output logic [1:0] state,
    output logic       run_led
);

    localparam int               DIV_W    = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam bit               STOP_EN  = (STOP_AT_END != 0);

    logic start_ev, clear_ev, lap_ev;
    logic tog_s1_q, tog_s2_q;

    ctrl_state_e      state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             hold_q, hold_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             run_led_q, run_led_d;
    logic             tick, term;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk_i(clk), .rst_ni(rst), .btn_i(btn_start), .press_o(start_ev)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk_i(clk), .rst_ni(rst), .btn_i(btn_clear), .press_o(clear_ev)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk_i(clk), .rst_ni(rst), .btn_i(btn_lap), .press_o(lap_ev)
    );

    assign tick = (state_q == ST_RUN) && (div_q == DIV_LAST);
    assign term = STOP_EN && is_terminal(bcd_10, bcd_1, cnt_up);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        hold_d    = hold_q;
        cnt_en_d  = 1'b0;
        cnt_clr_d = clear_ev;
        if (clear_ev) begin
            state_d = ST_IDLE;
            div_d   = '0;
            hold_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ev) begin
                        state_d = ST_RUN;
                        div_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (lap_ev)
                        hold_d = ~hold_q;
                    // A start press on the tick cycle pauses without advancing.
                    if (start_ev) begin
                        state_d = ST_PAUSE;
                    end else if (tick) begin
                        div_d = '0;
                        if (term)
                            state_d = ST_DONE;
                        else
                            cnt_en_d = 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (lap_ev)
                        hold_d = ~hold_q;
                    if (start_ev)
                        state_d = ST_RUN;
                end
                default: ;
            endcase
            if (state_d == ST_DONE)
                hold_d = 1'b0;
        end
        run_led_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            hold_q    <= 1'b0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            run_led_q <= 1'b0;
            tog_s1_q  <= 1'b0;
            tog_s2_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            run_led_q <= run_led_d;
            tog_s1_q  <= toggle;
            tog_s2_q  <= tog_s1_q;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign cnt_up    = ~tog_s2_q;
    assign disp_hold = hold_q;
    assign state     = state_q;
    assign run_led   = run_led_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a window-based behavioural model.
module tb_counter_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bs = 1'b0, bc = 1'b0, bl = 1'b0, tg = 1'b0;
    logic [3:0] b1 = 4'd0, b10 = 4'd0;

    logic       a_en, a_clr, a_up, a_hold, a_led;
    logic [1:0] a_state;
    logic       b_en, b_clr, b_up, b_hold, b_led;
    logic [1:0] b_state;

    counter_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB), .STOP_AT_END(1)) dut_a (
        .clk(clk), .rst(rst), .btn_start(bs), .btn_clear(bc), .btn_lap(bl),
        .toggle(tg), .bcd_1(b1), .bcd_10(b10),
        .cnt_en(a_en), .cnt_clr(a_clr), .cnt_up(a_up), .disp_hold(a_hold),
        .state(a_state), .run_led(a_led)
    );

    counter_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DB), .STOP_AT_END(0)) dut_b (
        .clk(clk), .rst(rst), .btn_start(bs), .btn_clear(bc), .btn_lap(bl),
        .toggle(tg), .bcd_1(b1), .bcd_10(b10),
        .cnt_en(b_en), .cnt_clr(b_clr), .cnt_up(b_up), .disp_hold(b_hold),
        .state(b_state), .run_led(b_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int en_seen = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: per-config FSM state plus shared input conditioning.
    int m_st[2], m_div[2];
    bit m_hold[2], m_en[2], m_clr[2], m_led[2];
    bit m_s1[4], m_s2[4], m_deb[3], m_ev[3];
    bit m_hist[3][DB];

    task automatic model_step();
        bit raw[4];
        bit up, tick, term, old, all_diff;
        raw = '{bs, bc, bl, tg};
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                m_st[c] = 0; m_div[c] = 0; m_hold[c] = 0;
                m_en[c] = 0; m_clr[c] = 0; m_led[c] = 0;
            end
            for (int k = 0; k < 4; k++) begin m_s1[k] = 0; m_s2[k] = 0; end
            for (int k = 0; k < 3; k++) begin
                m_deb[k] = 0; m_ev[k] = 0;
                for (int i = 0; i < DB; i++) m_hist[k][i] = 0;
            end
            return;
        end
        up = !m_s2[3];
        for (int c = 0; c < 2; c++) begin
            tick = (m_st[c] == 1) && (m_div[c] == TD - 1);
            term = tick && (c == 0) &&
                   ((up && b10 == 9 && b1 == 9) || (!up && b10 == 0 && b1 == 0));
            m_en[c]  = tick && !m_ev[0] && !m_ev[1] && !term;
            m_clr[c] = m_ev[1];
            if (m_ev[1]) begin
                m_st[c] = 0; m_div[c] = 0; m_hold[c] = 0;
            end else begin
                case (m_st[c])
                    0: if (m_ev[0]) begin m_st[c] = 1; m_div[c] = 0; end
                    1: begin
                        if (m_ev[2]) m_hold[c] = !m_hold[c];
                        if (m_ev[0]) m_st[c] = 2;
                        else if (term) m_st[c] = 3;
                        else m_div[c] = (m_div[c] + 1) % TD;
                    end
                    2: begin
                        if (m_ev[2]) m_hold[c] = !m_hold[c];
                        if (m_ev[0]) m_st[c] = 1;
                    end
                    default: ;
                endcase
                if (m_st[c] == 3) m_hold[c] = 0;
            end
            m_led[c] = (m_st[c] == 1);
        end
        // Debounced level flips once the last DB synchronized samples all disagree with it.
        for (int k = 0; k < 3; k++) begin
            old = m_deb[k];
            for (int i = 0; i < DB - 1; i++) m_hist[k][i] = m_hist[k][i+1];
            m_hist[k][DB-1] = m_s2[k];
            all_diff = 1;
            for (int i = 0; i < DB; i++) if (m_hist[k][i] == m_deb[k]) all_diff = 0;
            if (all_diff) m_deb[k] = !m_deb[k];
            m_ev[k] = m_deb[k] && !old;
        end
        for (int k = 0; k < 4; k++) begin
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (a_en) en_seen++;
        check_val("a.state", a_state, m_st[0]);
        check_val("a.cnt_en", a_en, m_en[0]);
        check_val("a.cnt_clr", a_clr, m_clr[0]);
        check_val("a.cnt_up", a_up, !m_s2[3]);
        check_val("a.disp_hold", a_hold, m_hold[0]);
        check_val("a.run_led", a_led, m_led[0]);
        check_val("b.state", b_state, m_st[1]);
        check_val("b.cnt_en", b_en, m_en[1]);
        check_val("b.cnt_clr", b_clr, m_clr[1]);
        check_val("b.cnt_up", b_up, !m_s2[3]);
        check_val("b.disp_hold", b_hold, m_hold[1]);
        check_val("b.run_led", b_led, m_led[1]);
    endtask

    task automatic press(input int k, input int len);
        case (k)
            0: bs = 1'b1;
            1: bc = 1'b1;
            default: bl = 1'b1;
        endcase
        repeat (len) cycle();
        bs = 1'b0; bc = 1'b0; bl = 1'b0;
        repeat (12) cycle();
    endtask

    initial begin
        int dur[4];
        logic [3:0] lvl;

        rst = 1'b0;
        repeat (2) cycle();
        check_val("rst_state", a_state, 0);
        check_val("rst_cnt_up", a_up, 1);
        check_val("rst_run_led", a_led, 0);
        rst = 1'b1;
        cycle();

        // Start press: RUN exactly six edges after the raw edge.
        bs = 1'b1;
        repeat (5) cycle();
        check_val("start_lat5", a_state, 0);
        cycle();
        check_val("start_lat6", a_state, 1);
        repeat (4) cycle();
        bs = 1'b0;
        repeat (30) cycle();

        press(0, 4); repeat (20) cycle();
        press(0, 4); repeat (10) cycle();

        b10 = 4'd9; b1 = 4'd9;
        repeat (10) cycle();
        check_val("done_at_99", a_state, 3);
        check_val("wrap_at_99", b_state, 1);
        press(0, 4);
        check_val("done_ignores_start", a_state, 3);
        press(1, 4);
        check_val("clear_to_idle", a_state, 0);

        tg = 1'b1; b10 = 4'd0; b1 = 4'd0;
        repeat (4) cycle();
        check_val("down_dir", a_up, 0);
        press(0, 4); repeat (20) cycle();
        check_val("done_at_00", a_state, 3);
        press(1, 4);

        press(0, 4); press(0, 4);
        bs = 1'b1; bc = 1'b1;
        repeat (5) cycle();
        bs = 1'b0; bc = 1'b0;
        repeat (12) cycle();
        check_val("start_clear_same", a_state, 0);

        tg = 1'b0; b10 = 4'd5; b1 = 4'd5;
        repeat (4) cycle();
        press(0, 4);
        press(2, 4);
        check_val("lap_on", a_hold, 1);
        press(2, 4);
        check_val("lap_off", a_hold, 0);
        for (int i = 0; i < 4; i++) begin
            bs = 1'b1; bl = 1'b1; repeat (2) cycle();
            bs = 1'b0; bl = 1'b0; repeat (3) cycle();
        end
        check_val("glitch_no_event", a_state, 1);
        rst = 1'b0;
        cycle();
        check_val("midrun_rst_state", a_state, 0);
        check_val("midrun_rst_led", a_led, 0);
        rst = 1'b1;
        cycle();

        for (int k = 0; k < 4; k++) dur[k] = 0;
        lvl = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (dur[k] == 0) begin
                    if (k == 1) lvl[k] = ($urandom_range(0, 5) == 0);
                    else        lvl[k] = ~lvl[k];
                    if (k == 3)      dur[k] = $urandom_range(20, 200);
                    else if (lvl[k]) dur[k] = $urandom_range(1, 14);
                    else             dur[k] = $urandom_range(3, 60);
                end else begin
                    dur[k]--;
                end
            end
            bs = lvl[0]; bc = lvl[1]; bl = lvl[2]; tg = lvl[3];
            if ($urandom_range(0, 14) == 0) begin
                case ($urandom_range(0, 3))
                    0:       begin b10 = 4'd9; b1 = 4'd9; end
                    1:       begin b10 = 4'd0; b1 = 4'd0; end
                    default: begin b10 = 4'($urandom_range(0, 15)); b1 = 4'($urandom_range(0, 15)); end
                endcase
            end
            rst = ($urandom_range(0, 499) != 0);
            cycle();
        end
        rst = 1'b1;

        check_val("cnt_en_seen", (en_seen > 0) ? 1 : 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
